// File: rtl/multi_stream_sink_pkg.sv
// Shared types and sizing for the multi-lane per-packet stream sink.
package multi_stream_sink_pkg;

    localparam int unsigned NUM_STREAMS = 4;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned SID_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned KEEP_W      = 1;

    typedef enum logic [1:0] {
        ModePass  = 2'd0,
        ModeDrop  = 2'd1,
        ModeTrunc = 2'd2,
        ModeRsvd  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [SID_W-1:0] sid;
        mode_e            mode;
        logic [LEN_W-1:0] max_beats;
    } cfg_t;

endpackage

// File: rtl/multi_stream_sink_if.sv
// Config port plus all per-lane input/output ndata streams of the sink.
// master = traffic/config source and output consumer; slave = the sink itself.
interface multi_stream_sink_if;
    import multi_stream_sink_pkg::*;

    logic                                 cfg_valid;
    logic                                 cfg_ready;
    cfg_t                                 cfg;

    logic [NUM_STREAMS-1:0][DATA_W-1:0]   in_data;
    logic [NUM_STREAMS-1:0][KEEP_W-1:0]   in_keep;
    logic [NUM_STREAMS-1:0]               in_last;
    logic [NUM_STREAMS-1:0]               in_valid;
    logic [NUM_STREAMS-1:0]               in_ready;

    logic [NUM_STREAMS-1:0][DATA_W-1:0]   out_data;
    logic [NUM_STREAMS-1:0][KEEP_W-1:0]   out_keep;
    logic [NUM_STREAMS-1:0]               out_last;
    logic [NUM_STREAMS-1:0]               out_valid;
    logic [NUM_STREAMS-1:0]               out_ready;

    modport master (
        output cfg_valid, cfg,
        input  cfg_ready,
        output in_data, in_keep, in_last, in_valid,
        input  in_ready,
        input  out_data, out_keep, out_last, out_valid,
        output out_ready
    );

    modport slave (
        input  cfg_valid, cfg,
        output cfg_ready,
        input  in_data, in_keep, in_last, in_valid,
        output in_ready,
        output out_data, out_keep, out_last, out_valid,
        input  out_ready
    );

endinterface

// File: rtl/multi_stream_sink_cfg_fifo.sv
// Per-lane config queue: synchronous FIFO with show-ahead head and same-cycle push/pop.
module multi_stream_sink_cfg_fifo
    import multi_stream_sink_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cfg_t wdata_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output cfg_t head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OccW = PtrW + 1;

    cfg_t            mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [OccW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == OccW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

    // Pointer/occupancy update; push is gated by the pre-pop full flag.
    always_comb begin
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OccW'(1);
            2'b01:   count_d = count_q - OccW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only looked at while count_q covers it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/multi_stream_sink.sv
// Multi-lane per-packet stream gate: each lane consumes one queued config per packet and
// passes, drops or truncates it, counting dropped beats per lane.
module multi_stream_sink
    import multi_stream_sink_pkg::*;
#(
    parameter int unsigned CfgDepth = 4,
    parameter int unsigned CntW     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_stream_sink_if.slave          bus,
    input  logic                        clr_stats_i,
    output logic [NUM_STREAMS*CntW-1:0] drop_cnt_o
);

    logic [NUM_STREAMS-1:0] fifo_push;
    logic [NUM_STREAMS-1:0] fifo_pop;
    logic [NUM_STREAMS-1:0] fifo_full;
    logic [NUM_STREAMS-1:0] fifo_empty;
    cfg_t                   fifo_head [NUM_STREAMS];
    logic                   cfg_ready;

    // Config acceptance looks only at the addressed lane's registered fullness;
    // out-of-range stream ids are swallowed so the port never stalls on them.
    always_comb begin
        cfg_ready = 1'b1;
        if (32'(bus.cfg.sid) < NUM_STREAMS) begin
            cfg_ready = ~fifo_full[bus.cfg.sid];
        end
    end

    assign bus.cfg_ready = cfg_ready;

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_lane
        logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
        logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;
        cfg_t             head;
        logic             head_vld;
        logic             fwd;
        logic             lane_last;
        logic             lane_out_valid;
        logic             lane_in_ready;
        logic             accept;
        logic             drop;

        assign fifo_push[i] = bus.cfg_valid & cfg_ready & (bus.cfg.sid == SID_W'(i));

        multi_stream_sink_cfg_fifo #(
            .Depth (CfgDepth)
        ) u_cfg_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (fifo_push[i]),
            .wdata_i (bus.cfg),
            .pop_i   (fifo_pop[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i]),
            .head_o  (fifo_head[i])
        );

        // Forward/discard decision from the head config and the beat position in the packet.
        always_comb begin
            head      = fifo_head[i];
            head_vld  = ~fifo_empty[i];
            fwd       = 1'b0;
            lane_last = bus.in_last[i];
            if (head_vld) begin
                case (head.mode)
                    ModePass: fwd = 1'b1;
                    ModeTrunc: begin
                        fwd = (beat_cnt_q < head.max_beats);
                        if (beat_cnt_q == head.max_beats - LEN_W'(1)) begin
                            lane_last = 1'b1;
                        end
                    end
                    default: fwd = 1'b0;
                endcase
            end
            lane_out_valid = head_vld & fwd & bus.in_valid[i];
            lane_in_ready  = head_vld & (fwd ? bus.out_ready[i] : 1'b1);
            accept         = bus.in_valid[i] & lane_in_ready;
            drop           = accept & ~fwd;
        end

        // Beat position within the current packet; restarts once the last beat is taken.
        always_comb begin
            beat_cnt_d = beat_cnt_q;
            if (accept) begin
                if (bus.in_last[i]) begin
                    beat_cnt_d = '0;
                end else if (beat_cnt_q != '1) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                end
            end
        end

        // Dropped-beat statistic; a clear wins over a same-cycle drop.
        always_comb begin
            drop_cnt_d = drop_cnt_q;
            if (clr_stats_i) begin
                drop_cnt_d = '0;
            end else if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + CntW'(1);
            end
        end

        // Lane state registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                beat_cnt_q <= '0;
                drop_cnt_q <= '0;
            end else begin
                beat_cnt_q <= beat_cnt_d;
                drop_cnt_q <= drop_cnt_d;
            end
        end

        assign fifo_pop[i]                  = accept & bus.in_last[i];
        assign bus.in_ready[i]              = lane_in_ready;
        assign bus.out_valid[i]             = lane_out_valid;
        assign bus.out_last[i]              = lane_last;
        assign bus.out_data[i]              = bus.in_data[i];
        assign bus.out_keep[i]              = bus.in_keep[i];
        assign drop_cnt_o[i*CntW +: CntW]   = drop_cnt_q;
    end

endmodule

// File: tb/tb_multi_stream_sink.sv
// Directed table-driven bench for multi_stream_sink plus hand sequences for multi-cycle cases.
module tb_multi_stream_sink;
    import multi_stream_sink_pkg::*;

    localparam int unsigned CntW = 4;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        clr_stats = 1'b0;
    logic [NUM_STREAMS*CntW-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    multi_stream_sink_if bus ();

    multi_stream_sink #(
        .CfgDepth (4),
        .CntW     (CntW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .clr_stats_i (clr_stats),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    lane;
        int    iv;
        int    d;
        int    l;
        int    ordy;
        int    cv;
        int    csid;
        mode_e cmode;
        int    cmax;
        int    e_ov;
        int    e_ir;
        int    e_ol;
        int    e_cr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(int lane, int iv, int d, int l, int ordy, int cv, int csid, mode_e cmode,
                       int cmax, int e_ov, int e_ir, int e_ol, int e_cr);
        vec_t v;
        v = '{lane, iv, d, l, ordy, cv, csid, cmode, cmax, e_ov, e_ir, e_ol, e_cr};
        vecs.push_back(v);
    endtask

    function automatic int lane_cnt(int i);
        return int'(drop_cnt[i*CntW +: CntW]);
    endfunction

    task automatic idle_all();
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.in_keep   = '1;
        bus.out_ready = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg       = '0;
    endtask

    task automatic push_cfg(int sid, mode_e m, int mb);
        bus.cfg_valid     = 1'b1;
        bus.cfg.sid       = SID_W'(sid);
        bus.cfg.mode      = m;
        bus.cfg.max_beats = LEN_W'(mb);
    endtask

    task automatic apply(vec_t v);
        idle_all();
        bus.in_valid[v.lane]  = 1'(v.iv);
        bus.in_data[v.lane]   = DATA_W'(v.d);
        bus.in_last[v.lane]   = 1'(v.l);
        bus.out_ready[v.lane] = 1'(v.ordy);
        bus.cfg.sid           = SID_W'(v.csid);
        if (v.cv != 0) push_cfg(v.csid, v.cmode, v.cmax);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int sent;
        int rcv;
        int cycles;

        // lane, iv, d, l, ordy, cv, csid, mode, max, exp ov, ir, ol, cfg_ready
        // PASS lane 0: config in the same cycle as data must not open the lane yet.
        add(0, 1, 'h10, 0, 1, 1, 0, ModePass, 0, 0, 0, 0, 1);
        add(0, 1, 'h10, 0, 1, 0, 0, ModePass, 0, 1, 1, 0, 1);
        add(0, 1, 'h11, 0, 1, 0, 0, ModePass, 0, 1, 1, 0, 1);
        add(0, 1, 'h12, 0, 1, 0, 0, ModePass, 0, 1, 1, 0, 1);
        add(0, 1, 'h13, 1, 1, 0, 0, ModePass, 0, 1, 1, 1, 1);
        // DROP lane 1: beats taken regardless of out_ready.
        add(1, 0, 0,     0, 1, 1, 1, ModeDrop, 0, 0, 0, 0, 1);
        add(1, 1, 'h20, 0, 0, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(1, 1, 'h21, 0, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(1, 1, 'h22, 1, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        // TRUNC max 2 on a 5-beat packet, with one stall cycle.
        add(2, 0, 0,     0, 1, 1, 2, ModeTrunc, 2, 0, 0, 0, 1);
        add(2, 1, 'h30, 0, 0, 0, 0, ModePass, 0, 1, 0, 0, 1);
        add(2, 1, 'h30, 0, 1, 0, 0, ModePass, 0, 1, 1, 0, 1);
        add(2, 1, 'h31, 0, 1, 0, 0, ModePass, 0, 1, 1, 1, 1);
        add(2, 1, 'h32, 0, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(2, 1, 'h33, 0, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(2, 1, 'h34, 1, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        // TRUNC max 8 on a 3-beat packet: forwarded intact.
        add(2, 0, 0,     0, 1, 1, 2, ModeTrunc, 8, 0, 0, 0, 1);
        add(2, 1, 'h40, 0, 1, 0, 0, ModePass, 0, 1, 1, 0, 1);
        add(2, 1, 'h41, 0, 1, 0, 0, ModePass, 0, 1, 1, 0, 1);
        add(2, 1, 'h42, 1, 1, 0, 0, ModePass, 0, 1, 1, 1, 1);
        // TRUNC max 0: whole packet dropped; reserved mode behaves as DROP.
        add(2, 0, 0,     0, 1, 1, 2, ModeTrunc, 0, 0, 0, 0, 1);
        add(2, 1, 'h50, 0, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(2, 1, 'h51, 1, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(2, 0, 0,     0, 1, 1, 2, ModeRsvd, 5, 0, 0, 0, 1);
        add(2, 1, 'h55, 1, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        // Lane 3 preload PASS, DROP, TRUNC1, PASS then a refused 5th.
        add(3, 0, 0,     0, 0, 1, 3, ModePass, 0, 0, 0, 0, 1);
        add(3, 0, 0,     0, 0, 1, 3, ModeDrop, 0, 0, 0, 0, 1);
        add(3, 0, 0,     0, 0, 1, 3, ModeTrunc, 1, 0, 0, 0, 1);
        add(3, 0, 0,     0, 0, 1, 3, ModePass, 0, 0, 0, 0, 1);
        add(3, 0, 0,     0, 0, 1, 3, ModePass, 7, 0, 0, 0, 0);
        add(3, 1, 'h60, 0, 1, 1, 3, ModePass, 7, 1, 1, 0, 0);
        add(3, 1, 'h61, 1, 1, 1, 3, ModePass, 7, 1, 1, 1, 0);
        add(3, 1, 'h62, 0, 1, 1, 3, ModePass, 7, 0, 1, 0, 1);
        add(3, 1, 'h63, 1, 1, 0, 0, ModePass, 0, 0, 1, 0, 1);
        add(3, 1, 'h64, 0, 1, 0, 0, ModePass, 0, 1, 1, 1, 1);
        add(3, 1, 'h65, 1, 1, 1, 3, ModePass, 0, 0, 1, 0, 1);
        add(3, 1, 'h66, 1, 1, 1, 3, ModeDrop, 0, 1, 1, 1, 1);
        add(3, 0, 0,     0, 0, 1, 3, ModePass, 0, 0, 0, 0, 1);
        add(3, 0, 0,     0, 0, 1, 3, ModePass, 0, 0, 0, 0, 0);

        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset in_ready", int'(bus.in_ready), 0);
        chk("reset cfg_ready", int'(bus.cfg_ready), 1);
        chk("reset drop_cnt", int'(drop_cnt), 0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            apply(vecs[k]);
            #1;
            chk($sformatf("row%0d cfg_ready", k), int'(bus.cfg_ready), vecs[k].e_cr);
            chk($sformatf("row%0d in_ready", k), int'(bus.in_ready[vecs[k].lane]), vecs[k].e_ir);
            chk($sformatf("row%0d out_valid", k), int'(bus.out_valid[vecs[k].lane]), vecs[k].e_ov);
            if (vecs[k].e_ov != 0) begin
                chk($sformatf("row%0d out_data", k), int'(bus.out_data[vecs[k].lane]), vecs[k].d);
                chk($sformatf("row%0d out_last", k), int'(bus.out_last[vecs[k].lane]), vecs[k].e_ol);
            end
        end
        @(negedge clk);
        idle_all();
        #1;
        chk("drop_cnt lane0", lane_cnt(0), 0);
        chk("drop_cnt lane1", lane_cnt(1), 3);
        chk("drop_cnt lane2", lane_cnt(2), 6);
        chk("drop_cnt lane3", lane_cnt(3), 3);

        // Lane 0 stays blocked without config while lane 1 PASS runs under random back-pressure.
        push_cfg(1, ModePass, 0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        sent = 0;
        rcv = 0;
        cycles = 0;
        bus.in_valid[0] = 1'b1;
        bus.in_data[0] = 8'hEE;
        bus.out_ready[0] = 1'b1;
        while (rcv < 8 && cycles < 200) begin
            bus.in_valid[1] = 1'b1;
            bus.in_data[1] = DATA_W'(8'h80 + sent);
            bus.in_last[1] = (sent == 7);
            bus.out_ready[1] = 1'($urandom_range(0, 1));
            #1;
            chk("blocked lane0 in_ready", int'(bus.in_ready[0]), 0);
            chk("blocked lane0 out_valid", int'(bus.out_valid[0]), 0);
            if (bus.out_valid[1] && bus.out_ready[1]) begin
                chk("bp out_data", int'(bus.out_data[1]), 'h80 + rcv);
                chk("bp out_last", int'(bus.out_last[1]), (rcv == 7) ? 1 : 0);
                rcv++;
            end
            if (bus.in_valid[1] && bus.in_ready[1]) sent++;
            @(negedge clk);
            cycles++;
        end
        chk("bp beats received", rcv, 8);
        chk("bp beats sent", sent, 8);
        idle_all();

        // Reset in the middle of a lane 0 packet, with lane 3 queue full.
        push_cfg(0, ModePass, 0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.in_valid[0] = 1'b1;
        bus.in_data[0] = 8'h55;
        bus.out_ready[0] = 1'b1;
        #1;
        chk("midpkt out_valid", int'(bus.out_valid[0]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        bus.cfg.sid = SID_W'(3);
        #1;
        chk("rst lane0 in_ready", int'(bus.in_ready[0]), 0);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst lane3 cfg_ready", int'(bus.cfg_ready), 1);
        chk("rst drop_cnt", int'(drop_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post-rst lane0 waits", int'(bus.in_ready[0]), 0);

        // clr_stats beats a concurrent drop.
        idle_all();
        push_cfg(1, ModeDrop, 0);
        @(negedge clk);
        idle_all();
        bus.in_valid[1] = 1'b1;
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        #1;
        chk("clr wins", lane_cnt(1), 0);
        @(negedge clk);
        bus.in_last[1] = 1'b1;
        #1;
        chk("drop after clr", lane_cnt(1), 1);
        @(negedge clk);
        idle_all();
        #1;
        chk("drop after clr 2", lane_cnt(1), 2);

        // Saturation: 20 dropped beats into a 4-bit counter.
        push_cfg(2, ModeDrop, 0);
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            idle_all();
            bus.in_valid[2] = 1'b1;
            bus.in_last[2] = (b == 19);
            #1;
            chk($sformatf("sat beat%0d in_ready", b), int'(bus.in_ready[2]), 1);
        end
        @(negedge clk);
        idle_all();
        #1;
        chk("saturated", lane_cnt(2), 15);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        #1;
        chk("clr from saturated", lane_cnt(2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
